// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch codes, branch-op codes and FSM state encoding for the branch resolve path.
// Used by the comparator, the control unit and branch_resolve_unit.
package branch_resolve_unit_pkg;

  localparam logic [1:0] BR_EQ  = 2'b00;
  localparam logic [1:0] BR_LT  = 2'b01;
  localparam logic [1:0] BR_GT  = 2'b10;
  localparam logic [1:0] BR_INV = 2'b11;

  localparam logic [1:0] BROP_BEQ = 2'b00;
  localparam logic [1:0] BROP_BLT = 2'b01;
  localparam logic [1:0] BROP_BGT = 2'b10;
  localparam logic [1:0] BROP_JMP = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  // An invalid comparator code never matches a conditional op, so it falls out as not taken.
  function automatic logic branch_taken(input logic [1:0] op, input logic [1:0] br);
    logic tk;
    tk = 1'b0;
    case (op)
      BROP_BEQ: tk = (br == BR_EQ);
      BROP_BLT: tk = (br == BR_LT);
      BROP_BGT: tk = (br == BR_GT);
      BROP_JMP: tk = 1'b1;
      default:  tk = 1'b0;
    endcase
    return tk;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bru_target_adder.sv
// Branch target: branch PC plus the sign-extended word offset converted to bytes.
// Purely combinational; wraps modulo 2^PC_W.
module bru_target_adder #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned OFF_W = 8
) (
  input  logic [PC_W-1:0]         pc_br,
  input  logic signed [OFF_W-1:0] offset,
  output logic [PC_W-1:0]         target
);

  logic signed [PC_W-1:0] off_sext;

  assign off_sext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign target   = pc_br + {off_sext[PC_W-2:0], 1'b0};

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the fetch PC, resolves ID-stage branches and flushes IF/ID.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     OFF_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     FLUSH_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    branchValid,
  input  logic [1:0]              brOp,
  input  logic [1:0]              branch,
  input  logic signed [OFF_W-1:0] offset,
  output logic [PC_W-1:0]         pc,
  output logic                    flushIFID,
  output logic                    taken,
  output logic                    badCode
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]             brCount,
  output logic [15:0]             takenCount
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

  bru_state_e      state_q;
  logic [2:0]      cnt_q;
  logic [PC_W-1:0] pc_q, pc_d, pc_br, pc_tgt;
  logic            flush_q, taken_q, badcode_q;
  logic            decide, take_br, bad_br;

  // The branch sitting in ID was fetched one word before the current fetch address.
  assign pc_br   = pc_q - PC_W'(2);
  assign decide  = (state_q == ST_RUN) && branchValid && !stall;
  assign take_br = branch_taken(brOp, branch);
  assign bad_br  = (brOp != BROP_JMP) && (branch == BR_INV);

  bru_target_adder #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_target (
    .pc_br  (pc_br),
    .offset (offset),
    .target (pc_tgt)
  );

  always_comb begin
    pc_d = pc_q + PC_W'(2);
    if (stall)
      pc_d = pc_q;
    else if (decide && take_br)
      pc_d = pc_tgt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      taken_q   <= 1'b0;
      badcode_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      taken_q   <= decide && take_br;
      badcode_q <= decide && bad_br;
      if (!stall) begin
        case (state_q)
          ST_RUN: begin
            if (decide && take_br) begin
              state_q <= ST_FLUSH;
              cnt_q   <= FLUSH_INIT;
              flush_q <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (cnt_q == 3'd0) begin
              state_q <= ST_RUN;
              flush_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign pc        = pc_q;
  assign flushIFID = flush_q;
  assign taken     = taken_q;
  assign badCode   = badcode_q;

`ifdef BRU_STATS_EN
  logic [15:0] br_cnt_q, tkn_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      tkn_cnt_q <= '0;
    end else if (decide) begin
      br_cnt_q <= sat_inc16(br_cnt_q);
      if (take_br)
        tkn_cnt_q <= sat_inc16(tkn_cnt_q);
    end
  end

  assign brCount    = br_cnt_q;
  assign takenCount = tkn_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: reset, vector table, then reset during flush.
module tb_branch_resolve_unit;

  logic              clk = 1'b0;
  logic              rst_n, stall, branchValid;
  logic [1:0]        brOp, branch;
  logic signed [7:0] offset;
  logic [15:0]       pc;
  logic              flushIFID, taken, badCode;
`ifdef BRU_STATS_EN
  logic [15:0]       brCount, takenCount;
`endif

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic        st;
    logic        bv;
    logic [1:0]  op;
    logic [1:0]  br;
    logic [7:0]  off;
    logic [15:0] e_pc;
    logic        e_fl;
    logic        e_tk;
    logic        e_bad;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_W      (16),
    .OFF_W     (8),
    .RESET_PC  (16'h0000),
    .FLUSH_CYC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branchValid (branchValid),
    .brOp        (brOp),
    .branch      (branch),
    .offset      (offset),
    .pc          (pc),
    .flushIFID   (flushIFID),
    .taken       (taken),
    .badCode     (badCode)
`ifdef BRU_STATS_EN
    ,
    .brCount     (brCount),
    .takenCount  (takenCount)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic bv, input logic [1:0] op,
                       input logic [1:0] br, input logic [7:0] off);
    stall       = st;
    branchValid = bv;
    brOp        = op;
    branch      = br;
    offset      = off;
  endtask

  initial begin
    // Vectors start with pc=0010; each row is applied for one cycle then outputs checked.
    //                  st    bv    op     br     off    pc        fl    tk    bad
    vecs.push_back('{1'b0, 1'b1, 2'b00, 2'b00, 8'h04, 16'h0016, 1'b1, 1'b1, 1'b0}); // BEQ taken
    vecs.push_back('{1'b0, 1'b1, 2'b11, 2'b00, 8'h10, 16'h0018, 1'b1, 1'b0, 1'b0}); // JMP ignored in flush
    vecs.push_back('{1'b0, 1'b1, 2'b11, 2'b00, 8'h10, 16'h001A, 1'b0, 1'b0, 1'b0}); // JMP ignored in flush
    vecs.push_back('{1'b0, 1'b1, 2'b01, 2'b10, 8'h04, 16'h001C, 1'b0, 1'b0, 1'b0}); // BLT not taken
    vecs.push_back('{1'b0, 1'b1, 2'b10, 2'b10, 8'h03, 16'h0020, 1'b1, 1'b1, 1'b0}); // BGT taken
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0022, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0024, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 2'b11, 8'h05, 16'h0026, 1'b0, 1'b0, 1'b1}); // BEQ invalid code
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0028, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 2'b11, 8'hFE, 16'h0022, 1'b1, 1'b1, 1'b0}); // JMP ignores code
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0024, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0026, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 2'b00, 8'hF5, 16'h000E, 1'b1, 1'b1, 1'b0}); // JMP back
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0012, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 2'b01, 8'h80, 16'hFF10, 1'b1, 1'b1, 1'b0}); // -128 words from 0010
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'hFF12, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'hFF14, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 2'b01, 8'h75, 16'hFFFC, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'hFFFE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0}); // pc wraps
    vecs.push_back('{1'b0, 1'b1, 2'b00, 2'b00, 8'h02, 16'h0002, 1'b1, 1'b1, 1'b0}); // branch pc FFFE +2
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0004, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0006, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 2'b00, 8'h04, 16'h0008, 1'b0, 1'b0, 1'b0}); // BGT not taken
    vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 8'h04, 16'h0008, 1'b0, 1'b0, 1'b0}); // stalled branch
    vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 8'h04, 16'h0008, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 8'h04, 16'h0008, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 2'b00, 8'h04, 16'h000E, 1'b1, 1'b1, 1'b0}); // stall released
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 16'h000E, 1'b1, 1'b0, 1'b0}); // stall in flush
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 16'h0012, 1'b0, 1'b0, 1'b0});

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'h00);
    tick();
    tick();
    check("reset_pc", pc, 16'h0000);
    check("reset_flush", {15'd0, flushIFID}, 16'd0);
    check("reset_taken", {15'd0, taken}, 16'd0);
    check("reset_bad", {15'd0, badCode}, 16'd0);
`ifdef BRU_STATS_EN
    check("reset_brCount", brCount, 16'd0);
    check("reset_takenCount", takenCount, 16'd0);
`endif

    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("run_pc[%0d]", i), pc, 16'((i + 1) * 2));
      check($sformatf("run_flush[%0d]", i), {15'd0, flushIFID}, 16'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].bv, vecs[i].op, vecs[i].br, vecs[i].off);
      tick();
      check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d_flush", i), {15'd0, flushIFID}, {15'd0, vecs[i].e_fl});
      check($sformatf("vec%0d_taken", i), {15'd0, taken}, {15'd0, vecs[i].e_tk});
      check($sformatf("vec%0d_bad", i), {15'd0, badCode}, {15'd0, vecs[i].e_bad});
    end

`ifdef BRU_STATS_EN
    check("stats_brCount", brCount, 16'd11);
    check("stats_takenCount", takenCount, 16'd8);
`endif

    // Reset asserted while flushing, with stall also high: reset must win.
    drive(1'b0, 1'b1, 2'b11, 2'b00, 8'h00);
    tick();
    check("mid_jmp_pc", pc, 16'h0010);
    check("mid_jmp_flush", {15'd0, flushIFID}, 16'd1);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 8'h00);
    rst_n = 1'b0;
    tick();
    check("midrst_pc", pc, 16'h0000);
    check("midrst_flush", {15'd0, flushIFID}, 16'd0);
    check("midrst_taken", {15'd0, taken}, 16'd0);
`ifdef BRU_STATS_EN
    check("midrst_brCount", brCount, 16'd0);
    check("midrst_takenCount", takenCount, 16'd0);
`endif
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'h00);
    tick();
    check("post_rst_pc0", pc, 16'h0002);
    check("post_rst_flush0", {15'd0, flushIFID}, 16'd0);
    tick();
    check("post_rst_pc1", pc, 16'h0004);
    check("post_rst_flush1", {15'd0, flushIFID}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
